wave_gen: RTL and testbench

Programmable sample source for the waveform generator: a phase-accumulator oscillator producing sine, square, triangle or sawtooth at a fixed sample rate derived from `clk`. It sits directly upstream of the symmetric FIR smoothing filter. `o_cs` drives the filter's sample-enable and `o_sample` drives its signed 16-bit sample input. Output is amplitude-scaled and held stable between sample strobes.

---
 rtl/wave_gen.sv | 172 +++++++++++++++++
 tb/tb_wave_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator oscillator producing sine, square, triangle or sawtooth
// samples, amplitude-scaled, one new sample every CLK_DIV clocks.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous reset, active HIGH despite the name
//   i_en         in   run enable; low freezes the phase and clears the divider
//   i_freq_word  in   phase increment per sample (unsigned, PHASE_W bits)
//   i_wave_sel   in   0 sine, 1 square, 2 triangle, 3 sawtooth
//   i_amp        in   unsigned gain, i_amp/256
//   o_cs         out  one-cycle strobe, o_sample is new in this cycle
//   o_sample     out  signed 16-bit sample, held between strobes
module wave_gen #(
   parameter int unsigned CLK_DIV = 50,
   parameter int unsigned PHASE_W = 24
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_en,
   input  logic [PHASE_W-1:0]        i_freq_word,
   input  logic [1:0]                i_wave_sel,
   input  logic [7:0]                i_amp,
   output logic                      o_cs,
   output logic signed [15:0]        o_sample
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   // Divider and stage 0
   logic [DIV_W-1:0]   r_div_cnt;
   logic [PHASE_W-1:0] r_phase_acc;
   logic               w_tick;

   // Stage 1 inputs: only the 16 phase MSBs are ever used downstream
   logic               r_v1;
   logic [15:0]        r_ph_s1;
   logic [1:0]         r_sel_s1;
   logic [7:0]         r_amp_s1;

   // Stage 2 inputs
   logic               r_v2;
   logic signed [15:0] r_raw;
   logic [7:0]         r_amp_s2;

   // Output registers
   logic               r_cs;
   logic signed [15:0] r_sample;

   assign w_tick = i_en && (r_div_cnt == DIV_MAX);

   // ---------------- Stage 1 waveform shaping ----------------
   logic [15:0] w_p;
   logic [1:0]  w_q;
   logic [5:0]  w_a;
   logic [5:0]  w_idx;
   logic [15:0] w_rom;
   logic [15:0] w_sin;
   logic [14:0] w_t;
   logic [15:0] w_tri;
   logic [15:0] w_sqr;
   logic [15:0] w_saw;
   logic [15:0] w_raw;

   assign w_p   = r_ph_s1;
   assign w_q   = w_p[15:14];
   assign w_a   = w_p[13:8];
   // Odd quadrants read the quarter-wave table backwards (63 - a == ~a)
   assign w_idx = w_q[0] ? ~w_a : w_a;
   assign w_sin = w_q[1] ? (~w_rom + 16'd1) : w_rom;

   assign w_t   = w_p[15] ? ~w_p[14:0] : w_p[14:0];
   assign w_tri = {w_t, 1'b0} ^ 16'h8000;
   assign w_sqr = w_p[15] ? 16'h8000 : 16'h7FFF;
   assign w_saw = w_p ^ 16'h8000;

   // Quarter-wave sine, entry k = round(32767*sin(pi/2*(k+0.5)/64)); the last entry is
   // pinned at 32766 so the peak lands one code below full scale.
   always_comb begin
      w_rom = 16'd0;
      case (w_idx)
         6'd0:  w_rom = 16'd402;    6'd1:  w_rom = 16'd1206;   6'd2:  w_rom = 16'd2009;
         6'd3:  w_rom = 16'd2811;   6'd4:  w_rom = 16'd3612;   6'd5:  w_rom = 16'd4410;
         6'd6:  w_rom = 16'd5205;   6'd7:  w_rom = 16'd5998;   6'd8:  w_rom = 16'd6786;
         6'd9:  w_rom = 16'd7571;   6'd10: w_rom = 16'd8351;   6'd11: w_rom = 16'd9126;
         6'd12: w_rom = 16'd9896;   6'd13: w_rom = 16'd10659;  6'd14: w_rom = 16'd11417;
         6'd15: w_rom = 16'd12167;  6'd16: w_rom = 16'd12910;  6'd17: w_rom = 16'd13645;
         6'd18: w_rom = 16'd14372;  6'd19: w_rom = 16'd15090;  6'd20: w_rom = 16'd15800;
         6'd21: w_rom = 16'd16499;  6'd22: w_rom = 16'd17189;  6'd23: w_rom = 16'd17869;
         6'd24: w_rom = 16'd18537;  6'd25: w_rom = 16'd19195;  6'd26: w_rom = 16'd19841;
         6'd27: w_rom = 16'd20475;  6'd28: w_rom = 16'd21096;  6'd29: w_rom = 16'd21705;
         6'd30: w_rom = 16'd22301;  6'd31: w_rom = 16'd22884;  6'd32: w_rom = 16'd23452;
         6'd33: w_rom = 16'd24007;  6'd34: w_rom = 16'd24547;  6'd35: w_rom = 16'd25072;
         6'd36: w_rom = 16'd25582;  6'd37: w_rom = 16'd26077;  6'd38: w_rom = 16'd26556;
         6'd39: w_rom = 16'd27019;  6'd40: w_rom = 16'd27466;  6'd41: w_rom = 16'd27896;
         6'd42: w_rom = 16'd28310;  6'd43: w_rom = 16'd28706;  6'd44: w_rom = 16'd29085;
         6'd45: w_rom = 16'd29447;  6'd46: w_rom = 16'd29791;  6'd47: w_rom = 16'd30117;
         6'd48: w_rom = 16'd30424;  6'd49: w_rom = 16'd30714;  6'd50: w_rom = 16'd30985;
         6'd51: w_rom = 16'd31237;  6'd52: w_rom = 16'd31470;  6'd53: w_rom = 16'd31685;
         6'd54: w_rom = 16'd31880;  6'd55: w_rom = 16'd32057;  6'd56: w_rom = 16'd32213;
         6'd57: w_rom = 16'd32351;  6'd58: w_rom = 16'd32469;  6'd59: w_rom = 16'd32567;
         6'd60: w_rom = 16'd32646;  6'd61: w_rom = 16'd32705;  6'd62: w_rom = 16'd32745;
         6'd63: w_rom = 16'd32766;
      endcase
   end

   always_comb begin
      w_raw = 16'd0;
      unique case (r_sel_s1)
         2'd0: w_raw = w_sin;
         2'd1: w_raw = w_sqr;
         2'd2: w_raw = w_tri;
         2'd3: w_raw = w_saw;
      endcase
   end

   // ---------------- Stage 2 amplitude scaling ----------------
   // |raw * amp| <= 32768*255 < 2^23, so a 24-bit signed product cannot overflow.
   logic signed [23:0] w_prod;
   logic signed [15:0] w_scaled;

   assign w_prod   = 24'(r_raw) * 24'($signed({1'b0, r_amp_s2}));
   assign w_scaled = 16'(w_prod >>> 8);

   // ---------------- State ----------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_div_cnt   <= '0;
         r_phase_acc <= '0;
         r_v1        <= 1'b0;
         r_ph_s1     <= '0;
         r_sel_s1    <= '0;
         r_amp_s1    <= '0;
         r_v2        <= 1'b0;
         r_raw       <= '0;
         r_amp_s2    <= '0;
         r_cs        <= 1'b0;
         r_sample    <= '0;
      end else begin
         if (!i_en || w_tick) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end

         // Stage 0: sample uses the phase before this tick's increment
         r_v1 <= w_tick;
         if (w_tick) begin
            r_ph_s1     <= r_phase_acc[PHASE_W-1 -: 16];
            r_phase_acc <= r_phase_acc + i_freq_word;
            r_sel_s1    <= i_wave_sel;
            r_amp_s1    <= i_amp;
         end

         // Stage 1 keeps running with i_en low so an in-flight sample still completes
         r_v2 <= r_v1;
         if (r_v1) begin
            r_raw    <= w_raw;
            r_amp_s2 <= r_amp_s1;
         end

         r_cs <= r_v2;
         if (r_v2) begin
            r_sample <= w_scaled;
         end
      end
   end

   assign o_cs     = r_cs;
   assign o_sample = r_sample;

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: self-checking bench for wave_gen. A sample-level model (real-valued sine
// table, integer waveform formulas, a queue of pending samples keyed by due cycle) is
// compared against o_cs/o_sample every cycle; directed scenarios add literal expectations.
module tb_wave_gen;

   localparam int unsigned CLK_DIV = 50;
   localparam int unsigned PHASE_W = 24;
   localparam int unsigned PH_MASK = (1 << PHASE_W) - 1;

   logic                clk;
   logic                rst_n;
   logic                i_en;
   logic [PHASE_W-1:0]  i_freq_word;
   logic [1:0]          i_wave_sel;
   logic [7:0]          i_amp;
   logic                o_cs;
   logic signed [15:0]  o_sample;

   wave_gen #(
      .CLK_DIV (CLK_DIV),
      .PHASE_W (PHASE_W)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (i_en),
      .i_freq_word (i_freq_word),
      .i_wave_sel  (i_wave_sel),
      .i_amp       (i_amp),
      .o_cs        (o_cs),
      .o_sample    (o_sample)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;
   int lut[64];

   // Stimulus to apply in the next cycle
   logic               nx_rst;
   logic               nx_en;
   logic [PHASE_W-1:0] nx_freq;
   logic [1:0]         nx_sel;
   logic [7:0]         nx_amp;

   // Model state
   int          cyc;
   int          m_run;
   int unsigned m_phase;
   logic        m_cs;
   int          m_sample;
   int          pend_due[$];
   int          pend_val[$];
   int          log_cyc[$];
   int          log_val[$];

   function automatic int floor_div256(input int x);
      if (x >= 0) return x / 256;
      return -((-x + 255) / 256);
   endfunction

   function automatic int wave_val(input int unsigned ph, input int sel, input int amp);
      int p;
      int q;
      int a;
      int idx;
      int raw;
      p = int'(ph / (1 << (PHASE_W - 16)));
      case (sel)
         0: begin
            q   = p / 16384;
            a   = (p % 16384) / 256;
            idx = (q % 2 == 1) ? 63 - a : a;
            raw = (q >= 2) ? -lut[idx] : lut[idx];
         end
         1:       raw = (p < 32768) ? 32767 : -32768;
         2:       raw = (p < 32768) ? 2 * p - 32768 : 2 * (65535 - p) - 32768;
         default: raw = p - 32768;
      endcase
      return floor_div256(raw * amp);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // One clock: compare outputs of the current cycle, apply next inputs, advance the model.
   task automatic clk_cycle();
      @(negedge clk);
      cyc++;
      chk("o_cs", int'(o_cs), int'(m_cs));
      chk("o_sample", int'(o_sample), m_sample);
      if (o_cs) begin
         log_cyc.push_back(cyc);
         log_val.push_back(int'(o_sample));
      end
      rst_n       = nx_rst;
      i_en        = nx_en;
      i_freq_word = nx_freq;
      i_wave_sel  = nx_sel;
      i_amp       = nx_amp;
      if (nx_rst) begin
         pend_due.delete();
         pend_val.delete();
         m_phase  = 0;
         m_run    = 0;
         m_cs     = 1'b0;
         m_sample = 0;
      end else begin
         if (nx_en) begin
            if (m_run == int'(CLK_DIV) - 1) begin
               pend_due.push_back(cyc + 3);
               pend_val.push_back(wave_val(m_phase, int'(nx_sel), int'(nx_amp)));
               m_phase = (m_phase + int'(nx_freq)) & PH_MASK;
               m_run   = 0;
            end else begin
               m_run++;
            end
         end else begin
            m_run = 0;
         end
         m_cs = 1'b0;
         if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
            m_cs     = 1'b1;
            m_sample = pend_val[0];
            void'(pend_due.pop_front());
            void'(pend_val.pop_front());
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) clk_cycle();
   endtask

   task automatic do_reset(input int n);
      nx_rst = 1'b1;
      nx_en  = 1'b0;
      run(n);
      nx_rst = 1'b0;
      log_cyc.delete();
      log_val.delete();
   endtask

   // Applies the first enabled cycle; base is that cycle's number (cycle 0 of the latency).
   task automatic start(input int sel, input int amp, input int freq, output int base);
      nx_sel  = 2'(sel);
      nx_amp  = 8'(amp);
      nx_freq = PHASE_W'(freq);
      nx_en   = 1'b1;
      clk_cycle();
      base = cyc;
   endtask

   task automatic chk_log(input string name, input int idx, input int base, input int exp_off,
                          input int exp_val);
      if (idx >= log_val.size()) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: strobe %0d missing, got %0d strobes, expected at least %0d",
                  name, idx, log_val.size(), idx + 1);
      end else begin
         chk({name, "_cycle"}, log_cyc[idx] - base, exp_off);
         chk({name, "_value"}, log_val[idx], exp_val);
      end
   endtask

   int base;
   int base2;
   int sq_exp[4]  = '{16383, 16383, -16384, -16384};
   int sin_exp[4] = '{400, 32638, -401, -32639};
   int tri_exp[2] = '{-32640, 32638};

   initial begin
      for (int k = 0; k < 64; k++) begin
         lut[k] = int'($floor(32767.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 128.0)
                              + 0.5));
      end
      lut[63] = 32766;

      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      m_run    = 0;
      m_phase  = 0;
      m_cs     = 1'b0;
      m_sample = 0;
      rst_n       = 1'b1;
      i_en        = 1'b0;
      i_freq_word = '0;
      i_wave_sel  = '0;
      i_amp       = '0;
      nx_rst  = 1'b1;
      nx_en   = 1'b0;
      nx_freq = '0;
      nx_sel  = '0;
      nx_amp  = '0;

      // Sawtooth ramp, latency and period
      do_reset(3);
      chk("reset_cs", int'(o_cs), 0);
      chk("reset_sample", int'(o_sample), 0);
      start(3, 255, 24'h010000, base);
      run(52 + 150 + 5);
      chk_log("saw0", 0, base, 52, -32640);
      chk_log("saw1", 1, base, 102, -32385);
      chk_log("saw2", 2, base, 152, -32130);

      // Square
      do_reset(3);
      start(1, 128, 24'h400000, base);
      run(52 + 50 * 7 + 5);
      for (int i = 0; i < 8; i++) chk_log("square", i, base, 52 + 50 * i, sq_exp[i % 4]);

      // Sine
      do_reset(3);
      start(0, 255, 24'h400000, base);
      run(52 + 50 * 7 + 5);
      for (int i = 0; i < 8; i++) chk_log("sine", i, base, 52 + 50 * i, sin_exp[i % 4]);

      // Triangle with accumulator wrap
      do_reset(3);
      start(2, 255, 24'h800000, base);
      run(52 + 50 * 7 + 5);
      for (int i = 0; i < 8; i++) chk_log("triangle", i, base, 52 + 50 * i, tri_exp[i % 2]);

      // Enable gap: drop one cycle after the first tick, hold low 200 cycles
      do_reset(3);
      start(3, 255, 24'h010000, base);
      run(49);
      nx_en = 1'b0;
      run(200);
      chk("gap_strobes", log_val.size(), 1);
      chk_log("gap_inflight", 0, base, 52, -32640);
      nx_en = 1'b1;
      clk_cycle();
      base2 = cyc;
      run(60);
      chk("gap_resume_strobes", log_val.size(), 2);
      chk_log("gap_resume", 1, base2, 52, -32385);

      // Reset between a tick and its strobe
      do_reset(3);
      start(3, 255, 24'h010000, base);
      run(49);
      nx_rst = 1'b1;
      clk_cycle();
      nx_rst = 1'b0;
      clk_cycle();
      base2 = cyc;
      run(10);
      chk("rst_no_strobe", log_val.size(), 0);
      chk("rst_sample_zero", int'(o_sample), 0);
      run(50);
      chk_log("rst_restart", 0, base2, 52, -32640);

      // Randomised run against the model
      do_reset(2);
      nx_en   = 1'b1;
      nx_freq = PHASE_W'($urandom);
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(63) == 0) begin
            case ($urandom_range(3))
               0:       nx_freq = '0;
               1:       nx_freq = PHASE_W'($urandom_range(4095));
               default: nx_freq = PHASE_W'($urandom);
            endcase
         end
         if ($urandom_range(39) == 0) nx_sel = 2'($urandom_range(3));
         if ($urandom_range(39) == 0) nx_amp = 8'($urandom_range(255));
         if ($urandom_range(299) == 0) nx_en = ~nx_en;
         nx_rst = ($urandom_range(2999) == 0);
         clk_cycle();
         if (n_errors > 100) break;
      end
      nx_rst = 1'b0;
      run(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
